// File: rtl/axis_pkg.sv
// Shared constants, FSM state type and the byte-keep helper for the AXI-Stream packetizer.
package axis_pkg;

  localparam int DEF_DW   = 32;
  localparam int NB       = DEF_DW / 8;
  localparam int LGNB     = $clog2(NB);
  localparam int MAX_LGNB = LGNB + 5;
  localparam int MAX_NB   = 1 << MAX_LGNB;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } pkt_state_e;

  // Low min(rem, nb) bits set; callers size-cast the result to their own lane count.
  function automatic logic [MAX_NB-1:0] keep_mask(input logic [31:0] rem, input int unsigned nb);
    logic [MAX_NB-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_NB; i++) begin
      if ((i < nb) && (32'(i) < rem)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_packetizer_if.sv
// Input word stream, per-packet header fields and AXI-Stream master bus of the packetizer.
interface axis_packetizer_if #(
  parameter int DW    = 32,
  parameter int IDW   = 1,
  parameter int DESTW = 1,
  parameter int UW    = 1,
  parameter int LGLEN = 16
);
  logic               s_valid;
  logic               s_ready;
  logic [DW-1:0]      s_data;
  logic [LGLEN-1:0]   i_len;
  logic [IDW-1:0]     i_tid;
  logic [DESTW-1:0]   i_tdest;
  logic [UW-1:0]      i_tuser;
  logic               m_tvalid;
  logic               m_tready;
  logic [DW-1:0]      m_tdata;
  logic [DW/8-1:0]    m_tstrb;
  logic [DW/8-1:0]    m_tkeep;
  logic               m_tlast;
  logic [IDW-1:0]     m_tid;
  logic [DESTW-1:0]   m_tdest;
  logic [UW-1:0]      m_tuser;
  logic               o_busy;

  // Packetizer view: slave on the word stream, master on the AXI-Stream side.
  modport master (
    input  s_valid, s_data, i_len, i_tid, i_tdest, i_tuser, m_tready,
    output s_ready, m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser, o_busy
  );

  modport slave (
    output s_valid, s_data, i_len, i_tid, i_tdest, i_tuser, m_tready,
    input  s_ready, m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser, o_busy
  );
endinterface

// File: rtl/axis_skidbuffer.sv
// Two-entry skid buffer with fully registered outputs; input ready depends only on state.
module axis_skidbuffer #(
  parameter int PW = 8
) (
  input  logic          i_aclk,
  input  logic          i_areset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [PW-1:0] o_data
);
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] skid_data_q, skid_data_d;
  logic          ready_q, ready_d;
  logic          in_fire;
  logic          out_free;

  // Next-state: refill the output register from the skid entry first, then from the input.
  always_comb begin
    in_fire      = i_valid && ready_q;
    out_free     = !out_valid_q || i_ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (out_free) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = i_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = i_data;
      end
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    ready_d = !skid_valid_d;
  end

  // State registers; ready stays low through reset and its first clock.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;

endmodule

// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: cuts an unframed word stream into length-framed packets
// with TKEEP/TLAST and per-packet route fields, registered through a skid buffer.
module axis_packetizer
  import axis_pkg::*;
#(
  parameter int DW    = NB * 8,
  parameter int IDW   = 1,
  parameter int DESTW = 1,
  parameter int UW    = 1,
  parameter int LGLEN = 16
) (
  input logic               i_aclk,
  input logic               i_areset,
  axis_packetizer_if.master bus
);
  localparam int NBT = DW / 8;
  localparam int PW  = DW + NBT + 1 + IDW + DESTW + UW;
  localparam logic [LGLEN:0] FULL_LEN = {1'b1, {LGLEN{1'b0}}};
  localparam logic [LGLEN:0] NB_LEN   = (LGLEN+1)'(NBT);

  pkt_state_e       state_q, state_d;
  logic [LGLEN:0]   rem_q, rem_d;
  logic [IDW-1:0]   tid_q, tid_d;
  logic [DESTW-1:0] tdest_q, tdest_d;
  logic [UW-1:0]    tuser_q, tuser_d;

  logic             in_fire;
  logic             skid_ready;
  logic             beat_last;
  logic [LGLEN:0]   cur_rem;
  logic [NBT-1:0]   beat_keep;
  logic [DW-1:0]    beat_data;
  logic [IDW-1:0]   beat_tid;
  logic [DESTW-1:0] beat_tdest;
  logic [UW-1:0]    beat_tuser;
  logic [PW-1:0]    skid_in;
  logic [PW-1:0]    skid_out;
  logic [NBT-1:0]   out_keep;

  // Beat formation and FSM next-state; a packet's first word takes its header live from the inputs.
  always_comb begin
    in_fire    = bus.s_valid && skid_ready;
    cur_rem    = rem_q;
    beat_tid   = tid_q;
    beat_tdest = tdest_q;
    beat_tuser = tuser_q;
    if (state_q == IDLE) begin
      cur_rem    = (bus.i_len == '0) ? FULL_LEN : {1'b0, bus.i_len};
      beat_tid   = bus.i_tid;
      beat_tdest = bus.i_tdest;
      beat_tuser = bus.i_tuser;
    end else begin
      cur_rem    = rem_q;
    end
    beat_last = (cur_rem <= NB_LEN);
    beat_keep = NBT'(keep_mask(32'(cur_rem), NBT));
    for (int i = 0; i < NBT; i++) begin
      beat_data[8*i +: 8] = beat_keep[i] ? bus.s_data[8*i +: 8] : 8'h00;
    end

    state_d = state_q;
    rem_d   = rem_q;
    tid_d   = tid_q;
    tdest_d = tdest_q;
    tuser_d = tuser_q;
    if (in_fire) begin
      tid_d   = beat_tid;
      tdest_d = beat_tdest;
      tuser_d = beat_tuser;
      if (beat_last) begin
        state_d = IDLE;
        rem_d   = '0;
      end else begin
        state_d = BUSY;
        rem_d   = cur_rem - NB_LEN;
      end
    end else begin
      state_d = state_q;
    end
    skid_in = {beat_data, beat_keep, beat_last, beat_tid, beat_tdest, beat_tuser};
  end

  // FSM, remaining-byte counter and latched route fields.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tid_q   <= '0;
      tdest_q <= '0;
      tuser_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tid_q   <= tid_d;
      tdest_q <= tdest_d;
      tuser_q <= tuser_d;
    end
  end

  axis_skidbuffer #(.PW(PW)) u_skid (
    .i_aclk   (i_aclk),
    .i_areset (i_areset),
    .i_valid  (bus.s_valid),
    .o_ready  (skid_ready),
    .i_data   (skid_in),
    .o_valid  (bus.m_tvalid),
    .i_ready  (bus.m_tready),
    .o_data   (skid_out)
  );

  assign bus.s_ready = skid_ready;
  assign {bus.m_tdata, out_keep, bus.m_tlast, bus.m_tid, bus.m_tdest, bus.m_tuser} = skid_out;
  assign bus.m_tkeep = out_keep;
  assign bus.m_tstrb = out_keep;
  assign bus.o_busy  = (state_q == BUSY);

endmodule

// File: tb/tb_axis_packetizer.sv
// Scoreboard bench for axis_packetizer: packet-level reference model feeds an expected-beat
// queue; an independent monitor pops and compares every output handshake.
module tb_axis_packetizer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  tid;
    logic [1:0]  dest;
    logic [1:0]  user;
    int          acc;
    bit          strict;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   stall_left = 0;
  bit   rand_ready = 1'b0;
  bit   saw_block;
  beat_t exp_q[$];

  logic        tb_valid = 1'b0;
  logic [31:0] tb_data = 32'h0;
  logic [15:0] tb_len = 16'h0;
  logic [1:0]  tb_tid = 2'h0;
  logic [1:0]  tb_dest = 2'h0;
  logic [1:0]  tb_user = 2'h0;
  logic        tb_tready;

  axis_packetizer_if #(.DW(32), .IDW(2), .DESTW(2), .UW(2), .LGLEN(16)) bus ();
  axis_packetizer_if #(.DW(32), .IDW(2), .DESTW(2), .UW(2), .LGLEN(4))  bus4 ();

  axis_packetizer #(.DW(32), .IDW(2), .DESTW(2), .UW(2), .LGLEN(16)) dut (
    .i_aclk(clk), .i_areset(rst), .bus(bus));
  axis_packetizer #(.DW(32), .IDW(2), .DESTW(2), .UW(2), .LGLEN(4)) dut4 (
    .i_aclk(clk), .i_areset(rst), .bus(bus4));

  assign bus.s_valid  = tb_valid && !sel;
  assign bus.s_data   = tb_data;
  assign bus.i_len    = tb_len;
  assign bus.i_tid    = tb_tid;
  assign bus.i_tdest  = tb_dest;
  assign bus.i_tuser  = tb_user;
  assign bus.m_tready = tb_tready;
  assign bus4.s_valid  = tb_valid && sel;
  assign bus4.s_data   = tb_data;
  assign bus4.i_len    = tb_len[3:0];
  assign bus4.i_tid    = tb_tid;
  assign bus4.i_tdest  = tb_dest;
  assign bus4.i_tuser  = tb_user;
  assign bus4.m_tready = tb_tready;

  logic        mon_valid, mon_last, mon_s_ready, mon_busy;
  logic [31:0] mon_data;
  logic [3:0]  mon_keep, mon_strb;
  logic [1:0]  mon_tid, mon_dest, mon_user;
  assign mon_valid   = sel ? bus4.m_tvalid : bus.m_tvalid;
  assign mon_data    = sel ? bus4.m_tdata  : bus.m_tdata;
  assign mon_keep    = sel ? bus4.m_tkeep  : bus.m_tkeep;
  assign mon_strb    = sel ? bus4.m_tstrb  : bus.m_tstrb;
  assign mon_last    = sel ? bus4.m_tlast  : bus.m_tlast;
  assign mon_tid     = sel ? bus4.m_tid    : bus.m_tid;
  assign mon_dest    = sel ? bus4.m_tdest  : bus.m_tdest;
  assign mon_user    = sel ? bus4.m_tuser  : bus.m_tuser;
  assign mon_s_ready = sel ? bus4.s_ready  : bus.s_ready;
  assign mon_busy    = sel ? bus4.o_busy   : bus.o_busy;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    tb_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_left > 0) begin
        tb_tready = 1'b0;
        stall_left = stall_left - 1;
      end else if (rand_ready) begin
        tb_tready = ($urandom_range(0, 3) != 0);
      end else begin
        tb_tready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: byte n of a packet is valid while n < total length.
  function automatic beat_t model_beat(input int nbytes, input int idx, input logic [31:0] word,
                                       input logic [1:0] tid, input logic [1:0] dest, input logic [1:0] user);
    beat_t b;
    int left;
    int n;
    left = nbytes - 4 * idx;
    n = (left > 4) ? 4 : left;
    b.keep = 4'((1 << n) - 1);
    b.data = 32'h0;
    for (int k = 0; k < n; k++) b.data[8*k +: 8] = word[8*k +: 8];
    b.last = (left <= 4);
    b.tid = tid;
    b.dest = dest;
    b.user = user;
    b.acc = 0;
    b.strict = 1'b0;
    return b;
  endfunction

  // Monitor: compare every handshake against the queue head and check stall stability.
  initial begin
    logic [46:0] got, want, prev_pl;
    logic prev_valid, prev_ready, have_prev;
    beat_t e;
    have_prev = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_pl = 47'h0;
    forever begin
      @(negedge clk);
      got = {mon_data, mon_keep, mon_strb, mon_last, mon_tid, mon_dest, mon_user};
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && prev_valid && !prev_ready) begin
          n_tests++;
          if (!(mon_valid === 1'b1 && got === prev_pl)) begin
            n_fail++;
            $display("FAIL stall_hold valid=%b got=%h required=%h", mon_valid, got, prev_pl);
          end
        end
        if (mon_valid && tb_tready) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat got=%h required=none", got);
          end else begin
            e = exp_q.pop_front();
            want = {e.data, e.keep, e.keep, e.last, e.tid, e.dest, e.user};
            if (got !== want) begin
              n_fail++;
              $display("FAIL beat got=%h required=%h", got, want);
            end
            if (e.strict) begin
              n_tests++;
              if (cyc != e.acc + 1) begin
                n_fail++;
                $display("FAIL latency got_cycle=%0d required=%0d", cyc, e.acc + 1);
              end
            end
          end
        end
        prev_valid = mon_valid;
        prev_ready = tb_tready;
        prev_pl = got;
        have_prev = 1'b1;
      end
    end
  end

  // Present one word; called and returns one time unit after a rising edge.
  task automatic drive_word(input logic [31:0] d, input logic [15:0] len, input logic [1:0] tid,
                            input logic [1:0] dest, input logic [1:0] user, input beat_t e_in, input bit strict);
    beat_t e;
    int waited;
    bit got;
    e = e_in;
    waited = 0;
    got = 1'b0;
    tb_valid = 1'b1;
    tb_data = d;
    tb_len = len;
    tb_tid = tid;
    tb_dest = dest;
    tb_user = user;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (mon_s_ready) begin
        got = 1'b1;
        e.acc = cyc;
        e.strict = strict;
        exp_q.push_back(e);
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL s_ready_timeout got=0 required=1");
    end else if (mon_busy !== ~e.last) begin
      n_fail++;
      $display("FAIL o_busy got=%b required=%b", mon_busy, ~e.last);
    end
    tb_valid = 1'b0;
  endtask

  task automatic send_packet(input int len, input int lglen, input logic [1:0] tid, input logic [1:0] dest,
                             input logic [1:0] user, input int max_words, input int gap_max,
                             input logic [15:0] jlen, input logic [1:0] jdest, input bit fixed, input bit strict);
    int nbytes;
    int nwords;
    logic [31:0] d;
    beat_t e;
    nbytes = (len == 0) ? (1 << lglen) : len;
    nwords = (nbytes + 3) / 4;
    for (int w = 0; w < nwords && w < max_words; w++) begin
      d = fixed ? {4{8'((w + 1) * 17)}} : $urandom;
      e = model_beat(nbytes, w, d, tid, dest, user);
      if (w == 0) drive_word(d, len[15:0], tid, dest, user, e, strict);
      else drive_word(d, jlen, 2'($urandom), jdest, 2'($urandom), e, strict);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.m_tvalid, bus.s_ready, bus.o_busy, bus.m_tdata, bus.m_tkeep, bus.m_tlast} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_values got=%h required=0",
               {bus.m_tvalid, bus.s_ready, bus.o_busy, bus.m_tdata, bus.m_tkeep, bus.m_tlast});
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mon_valid, mon_s_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_cycle0 got=%b required=00", {mon_valid, mon_s_ready});
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({mon_valid, mon_s_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL post_reset_cycle1 got=%b required=01", {mon_valid, mon_s_ready});
    end

    // Fixed 10-byte packet, three known words.
    send_packet(10, 16, 2'd2, 2'd1, 2'd3, 99, 0, 16'd7, 2'd2, 1'b1, 1'b1);
    drain(50);

    // One-beat packet then a two-beat packet, back to back.
    send_packet(4, 16, 2'd1, 2'd2, 2'd0, 99, 0, 16'd3, 2'd0, 1'b0, 1'b1);
    send_packet(8, 16, 2'd3, 2'd0, 2'd1, 99, 0, 16'd3, 2'd1, 1'b0, 1'b1);
    drain(50);

    // Five-cycle output stall in the middle of a 16-byte packet.
    saw_block = 1'b0;
    fork
      send_packet(16, 16, 2'd2, 2'd3, 2'd1, 99, 0, 16'd16, 2'd3, 1'b0, 1'b0);
      begin
        k = 0;
        while (!mon_valid && k < 50) begin
          @(negedge clk);
          k++;
        end
        stall_left = 5;
        repeat (8) begin
          @(negedge clk);
          if (!mon_s_ready) saw_block = 1'b1;
        end
      end
    join
    drain(100);
    n_tests++;
    if (!saw_block) begin
      n_fail++;
      $display("FAIL s_ready_backpressure got=0 required=1");
    end

    // Header inputs change mid-packet and must be ignored.
    send_packet(12, 16, 2'd1, 2'd1, 2'd2, 99, 0, 16'd2, 2'd0, 1'b0, 1'b1);
    drain(50);

    // Reset while beat 3 of a 16-byte packet is on the output.
    send_packet(16, 16, 2'd0, 2'd2, 2'd1, 3, 0, 16'd5, 2'd1, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.m_tvalid, bus.o_busy, bus.s_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async got=%b required=000", {bus.m_tvalid, bus.o_busy, bus.s_ready});
    end
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mon_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_after_reset got=%b required=0", mon_valid);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (mon_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_after_reset2 got=%b required=0", mon_valid);
    end
    send_packet(4, 16, 2'd3, 2'd3, 2'd3, 99, 0, 16'd9, 2'd0, 1'b0, 1'b1);
    drain(50);

    // Length 0 on the 4-bit-length instance means 16 bytes.
    sel = 1'b1;
    send_packet(0, 4, 2'd2, 2'd1, 2'd2, 99, 0, 16'd1, 2'd3, 1'b0, 1'b1);
    drain(50);
    sel = 1'b0;

    // Random lengths, gaps and output backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 25; p++) begin
      send_packet($urandom_range(1, 40), 16, 2'($urandom), 2'($urandom), 2'($urandom), 99, 2,
                  16'($urandom), 2'($urandom), 1'b0, 1'b0);
    end
    drain(400);
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Converts an unframed word stream (valid/ready, no framing) into an AXI-Stream master stream.
- Adds TLAST, TKEEP/TSTRB and per-packet TID/TDEST/TUSER, cut to a byte length sampled at the start of each packet.
- Sits directly upstream of any AXI-Stream slave. Its output must pass the team's AXI-Stream master formal property set.
- Output is fully registered through a skid buffer, so no combinational path runs from m_tready to s_ready.

Parameters:
- DW, 32, data width in bits; multiple of 8, ≥ 8.
- IDW, 1, TID width.
- DESTW, 1, TDEST width.
- UW, 1, TUSER width.
- LGLEN, 16, width of the packet length field in bytes.

Ports:
- i_aclk  in  1  clock; all logic on the rising edge.
- i_areset  in  1  asynchronous reset, active-high.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  DW  input word.
- i_len  in  LGLEN  packet length in bytes; 0 means 2^LGLEN.
- i_tid  in  IDW  packet ID, sampled with i_len.
- i_tdest  in  DESTW  packet destination, sampled with i_len.
- i_tuser  in  UW  packet user field, sampled with i_len.
- m_tvalid  out  1  AXI-Stream TVALID.
- m_tready  in  1  AXI-Stream TREADY.
- m_tdata  out  DW  TDATA.
- m_tstrb  out  DW/8  TSTRB; always equal to m_tkeep.
- m_tkeep  out  DW/8  TKEEP.
- m_tlast  out  1  TLAST.
- m_tid  out  IDW  TID.
- m_tdest  out  DESTW  TDEST.
- m_tuser  out  UW  TUSER.
- o_busy  out  1  a packet is in progress (FSM in BUSY).

Behaviour:
- Reset values: every output and register is 0 while i_areset is high, including m_tvalid, s_ready, o_busy and the remaining-byte counter; FSM = IDLE.
- First beat after reset: earliest input accept is the first cycle after reset deasserts. m_tvalid therefore cannot rise before the second cycle after deassert.
- Constant NB = DW/8.
- FSM, state IDLE:
  - On an input accept, latch: rem = (i_len==0 ? 2^LGLEN : i_len), held in LGLEN+1 bits; plus tid, tdest, tuser.
  - The word is emitted as beat 1.
  - If rem ≤ NB, that beat is last and the FSM stays in IDLE. Otherwise the FSM goes to BUSY with rem −= NB.
- FSM, state BUSY:
  - Each accept emits a beat using the latched route fields; i_len/i_tid/i_tdest/i_tuser are ignored.
  - Non-final beat (rem > NB): TKEEP = all ones; rem −= NB.
  - Final beat (rem ≤ NB): TKEEP low rem bits set, TLAST=1, then go to IDLE.
- Beat contents: TSTRB = TKEEP on every beat. Bytes with TKEEP=0 are driven 0.
- Handshake and latency:
  - s_ready = skid buffer not full.
  - Beat appears on m_* one cycle after its input accept (registered, latency 1).
  - Sustained throughput is 1 beat/clock with m_tready held high.
- Stall rule: while m_tvalid && !m_tready, m_tvalid and every m_* field hold stable; the skid buffer absorbs at most one in-flight beat.
- m_tvalid never falls without a handshake, except on reset.
- Simultaneous events: packet end and the next packet's first word accepted on consecutive cycles → back-to-back packets with no bubble.
- Reset mid-packet: the packet is dropped, no TLAST is emitted, m_tvalid goes low asynchronously, and the next packet starts clean from IDLE.
- Length arithmetic: rem counter is LGLEN+1 bits and never underflows. Beat count = ceil(len/NB).

Decomposition:
- Package axis_pkg holds:
  - function keep_mask(rem) → DW/8-bit mask of low min(rem,NB) bits;
  - localparams NB and LGNB;
  - FSM state enum {IDLE, BUSY}.
- One sub-module: axis_skidbuffer. It is a 2-entry registered skid buffer, parameterized on payload width, carrying {tdata, tkeep, tlast, tid, tdest, tuser}. It has the same i_aclk/i_areset convention and a registered output valid.

Test Plan:
- DW=32, i_len=10, i_tdest=1, m_tready=1, 3 words 0x11111111/0x22222222/0x33333333:
  - 3 beats, TKEEP F/F/3;
  - TLAST only on beat 3; beat 3 TDATA=0x00003333;
  - TDEST=1 on all beats; beats 1 cycle after accepts.
- i_len=4 then i_len=8, continuous input, m_tready=1:
  - packet A is 1 beat, TLAST=1, TKEEP=F;
  - packet B is 2 beats with no idle cycle between packets;
  - o_busy high only during B beat 1.
- m_tready low 5 cycles mid-packet (i_len=16):
  - m_* stable throughout the stall;
  - s_ready drops once skid is full;
  - no beat lost or duplicated; 4 beats total.
- Change i_len/i_tdest to 2/0 during a BUSY packet (i_len=12, tdest=1) → the packet still ends after 3 beats with tdest=1.
- Assert i_areset for 1 cycle after beat 2 of an i_len=16 packet:
  - m_tvalid low immediately; no TLAST;
  - next packet (i_len=4) emits a single TLAST beat;
  - m_tvalid stays low the cycle after reset deasserts.
- LGLEN=4, i_len=0 → 16-byte packet: 4 beats, TLAST on beat 4, TKEEP=F.
